// File: rtl/monobit_bit_framer.sv
// monobit_bit_framer: synchronizes an async entropy bit stream, buffers it and frames it into SEQ_LEN-bit sequences.
// Define MONOBIT_FRAMER_VN_EN to insert a von Neumann corrector ahead of the FIFO.
module monobit_bit_framer #(
    parameter int SEQ_LEN     = 128,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int OVF_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             raw_bit_i,
    input  logic             raw_clk_i,
    output logic             epsilon_vld_o,
    input  logic             epsilon_rdy_i,
    output logic             epsilon_dat_o,
    output logic             seq_first_o,
    output logic             seq_last_o,
    output logic [15:0]      seq_cnt_o,
    output logic             overflow_o,
    output logic [OVF_W-1:0] ovf_cnt_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(SEQ_LEN);

    logic [SYNC_STAGES-1:0] bit_sync_q, clk_sync_q;
    logic                   clk_prev_q;
    logic                   sample, sbit, push, push_bit;
    logic [FIFO_DEPTH-1:0]  mem_q;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [15:0]            seq_cnt_q, seq_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [OVF_W-1:0]       ovf_cnt_q, ovf_cnt_d;
    logic                   full, pop, wr, drop, at_last;

    assign sample = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q & enable_i;
    assign sbit   = bit_sync_q[SYNC_STAGES-1];

`ifdef MONOBIT_FRAMER_VN_EN
    typedef enum logic {EMPTY, HALF} pair_e;
    pair_e state_q, state_d;
    logic  b0_q, b0_d;

    always_comb begin
        state_d  = state_q;
        b0_d     = b0_q;
        push     = 1'b0;
        push_bit = b0_q;
        if (!enable_i)
            state_d = EMPTY;
        else if (sample) begin
            state_d = state_q == EMPTY ? HALF : EMPTY;
            b0_d    = state_q == EMPTY ? sbit : b0_q;
            push    = state_q == HALF && b0_q != sbit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            b0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
        end
    end
`else
    assign push     = sample;
    assign push_bit = sbit;
`endif

    assign full          = count_q == (PW+1)'(FIFO_DEPTH);
    assign at_last       = idx_q == IW'(SEQ_LEN - 1);
    assign epsilon_vld_o = (count_q != '0) & enable_i;
    assign epsilon_dat_o = epsilon_vld_o & mem_q[rd_ptr_q];
    assign seq_first_o   = epsilon_vld_o & (idx_q == '0);
    assign seq_last_o    = epsilon_vld_o & at_last;
    assign seq_cnt_o     = seq_cnt_q;
    assign overflow_o    = ovf_q;
    assign ovf_cnt_o     = ovf_cnt_q;
    assign pop           = epsilon_vld_o & epsilon_rdy_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr            = push & (~full | pop);
    assign drop          = push & full & ~pop;

    always_comb begin
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d  = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d   = count_q + (PW+1)'(wr) - (PW+1)'(pop);
        idx_d     = pop ? (at_last ? '0 : idx_q + IW'(1)) : idx_q;
        seq_cnt_d = pop && at_last ? seq_cnt_q + 16'd1 : seq_cnt_q;
        ovf_d     = ovf_q | drop;
        ovf_cnt_d = drop && !(&ovf_cnt_q) ? ovf_cnt_q + OVF_W'(1) : ovf_cnt_q;
        if (!enable_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_sync_q <= '0;
            clk_sync_q <= '0;
            clk_prev_q <= 1'b0;
            mem_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            seq_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            bit_sync_q <= {bit_sync_q[SYNC_STAGES-2:0], raw_bit_i};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], raw_clk_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            if (wr)
                mem_q[wr_ptr_q] <= push_bit;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            seq_cnt_q  <= seq_cnt_d;
            ovf_q      <= ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end
endmodule
